// File: rtl/pcache_arbiter_if.sv
// Bundle of the parameter-cache arbiter's tile control, parser write port,
// two reader ports and the cache-side address/write-enable.
interface pcache_arbiter_if #(
    parameter int TAG_W = 10
);
    logic             tile_start;
    logic             tile_end;
    logic             flush_done;

    logic             wr_req;
    logic             wr_gnt;
    logic [TAG_W-1:0] wr_tag;
    logic             pcache_full;
    logic [TAG_W:0]   alloc_count;

    logic             rd0_req;
    logic [TAG_W-1:0] rd0_tag;
    logic             rd0_gnt;
    logic             rd0_valid;
    logic             rd0_err;

    logic             rd1_req;
    logic [TAG_W-1:0] rd1_tag;
    logic             rd1_gnt;
    logic             rd1_valid;
    logic             rd1_err;

    logic [TAG_W-1:0] prim_tag;
    logic             pcache_write;

    // Arbiter side
    modport slave (
        input  tile_start, tile_end, wr_req, rd0_req, rd0_tag, rd1_req, rd1_tag,
        output flush_done, wr_gnt, wr_tag, pcache_full, alloc_count,
               rd0_gnt, rd0_valid, rd0_err, rd1_gnt, rd1_valid, rd1_err,
               prim_tag, pcache_write
    );

    // Requester / tile-controller side
    modport master (
        output tile_start, tile_end, wr_req, rd0_req, rd0_tag, rd1_req, rd1_tag,
        input  flush_done, wr_gnt, wr_tag, pcache_full, alloc_count,
               rd0_gnt, rd0_valid, rd0_err, rd1_gnt, rd1_valid, rd1_err,
               prim_tag, pcache_write
    );
endinterface

// File: rtl/pcache_arbiter.sv
// Round-robin sequencer for the single-port parameter cache: allocates tags to
// parser writes, shares the port with two readers, and runs the per-tile lifecycle.
module pcache_arbiter #(
    parameter int ENTRIES = 1024,
    parameter int TAG_W   = 10
) (
    input  logic             clock_i,
    input  logic             reset_i,
    pcache_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    typedef enum logic [1:0] {SRC_WR, SRC_RD0, SRC_RD1} src_t;

    localparam logic [TAG_W:0] ENTRIES_W = (TAG_W+1)'(ENTRIES);

    state_t           state_q, state_d;
    src_t             last_q, last_d;
    logic             wr_gnt_q, wr_gnt_d;
    logic             rd0_gnt_q, rd0_gnt_d;
    logic             rd1_gnt_q, rd1_gnt_d;
    logic [TAG_W-1:0] prim_tag_q, prim_tag_d;
    logic [TAG_W:0]   alloc_q, alloc_d;
    logic             err0_pend_q, err0_pend_d;
    logic             err1_pend_q, err1_pend_d;
    logic             rd0_valid_q, rd0_valid_d;
    logic             rd1_valid_q, rd1_valid_d;
    logic             rd0_err_q, rd0_err_d;
    logic             rd1_err_q, rd1_err_d;
    logic             flush_done_q, flush_done_d;

    logic full, grant_ok, w_el, r0_el, r1_el;
    logic pick_w, pick_r0, pick_r1;

    always_comb begin
        full     = (alloc_q == ENTRIES_W);
        // tile_start and tile_end both block granting on the edge they are seen
        grant_ok = (state_q == RUN) && !bus.tile_start && !bus.tile_end;
        w_el     = grant_ok && bus.wr_req  && !wr_gnt_q  && !full;
        r0_el    = grant_ok && bus.rd0_req && !rd0_gnt_q;
        r1_el    = grant_ok && bus.rd1_req && !rd1_gnt_q;

        pick_w  = 1'b0;
        pick_r0 = 1'b0;
        pick_r1 = 1'b0;
        case (last_q)
            SRC_WR: begin
                if (r0_el)      pick_r0 = 1'b1;
                else if (r1_el) pick_r1 = 1'b1;
                else if (w_el)  pick_w  = 1'b1;
            end
            SRC_RD0: begin
                if (r1_el)      pick_r1 = 1'b1;
                else if (w_el)  pick_w  = 1'b1;
                else if (r0_el) pick_r0 = 1'b1;
            end
            default: begin
                if (w_el)       pick_w  = 1'b1;
                else if (r0_el) pick_r0 = 1'b1;
                else if (r1_el) pick_r1 = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        wr_gnt_d     = 1'b0;
        rd0_gnt_d    = 1'b0;
        rd1_gnt_d    = 1'b0;
        prim_tag_d   = prim_tag_q;
        alloc_d      = alloc_q;
        err0_pend_d  = err0_pend_q;
        err1_pend_d  = err1_pend_q;
        rd0_valid_d  = rd0_gnt_q;
        rd1_valid_d  = rd1_gnt_q;
        rd0_err_d    = rd0_gnt_q & err0_pend_q;
        rd1_err_d    = rd1_gnt_q & err1_pend_q;
        flush_done_d = 1'b0;

        case (state_q)
            RUN:   if (bus.tile_end) state_d = FLUSH;
            FLUSH: begin
                // A grant issued last cycle still owes its valid; drain it first
                if (!(rd0_gnt_q || rd1_gnt_q)) begin
                    flush_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        if (bus.tile_start) begin
            state_d      = RUN;
            alloc_d      = '0;
            flush_done_d = 1'b0;
        end

        if (pick_w) begin
            wr_gnt_d   = 1'b1;
            prim_tag_d = alloc_q[TAG_W-1:0];
            alloc_d    = alloc_q + 1'b1;
            last_d     = SRC_WR;
        end else if (pick_r0) begin
            rd0_gnt_d   = 1'b1;
            prim_tag_d  = bus.rd0_tag;
            err0_pend_d = ({1'b0, bus.rd0_tag} >= alloc_q);
            last_d      = SRC_RD0;
        end else if (pick_r1) begin
            rd1_gnt_d   = 1'b1;
            prim_tag_d  = bus.rd1_tag;
            err1_pend_d = ({1'b0, bus.rd1_tag} >= alloc_q);
            last_d      = SRC_RD1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            last_q       <= SRC_RD1;
            wr_gnt_q     <= 1'b0;
            rd0_gnt_q    <= 1'b0;
            rd1_gnt_q    <= 1'b0;
            prim_tag_q   <= '0;
            alloc_q      <= '0;
            err0_pend_q  <= 1'b0;
            err1_pend_q  <= 1'b0;
            rd0_valid_q  <= 1'b0;
            rd1_valid_q  <= 1'b0;
            rd0_err_q    <= 1'b0;
            rd1_err_q    <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            wr_gnt_q     <= wr_gnt_d;
            rd0_gnt_q    <= rd0_gnt_d;
            rd1_gnt_q    <= rd1_gnt_d;
            prim_tag_q   <= prim_tag_d;
            alloc_q      <= alloc_d;
            err0_pend_q  <= err0_pend_d;
            err1_pend_q  <= err1_pend_d;
            rd0_valid_q  <= rd0_valid_d;
            rd1_valid_q  <= rd1_valid_d;
            rd0_err_q    <= rd0_err_d;
            rd1_err_q    <= rd1_err_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign bus.flush_done   = flush_done_q;
    assign bus.wr_gnt       = wr_gnt_q;
    assign bus.wr_tag       = prim_tag_q;
    assign bus.pcache_full  = full;
    assign bus.alloc_count  = alloc_q;
    assign bus.rd0_gnt      = rd0_gnt_q;
    assign bus.rd0_valid    = rd0_valid_q;
    assign bus.rd0_err      = rd0_err_q;
    assign bus.rd1_gnt      = rd1_gnt_q;
    assign bus.rd1_valid    = rd1_valid_q;
    assign bus.rd1_err      = rd1_err_q;
    assign bus.prim_tag     = prim_tag_q;
    assign bus.pcache_write = wr_gnt_q;
endmodule

// File: tb/tb_pcache_arbiter.sv
// Directed bench: a full-size arbiter for the lifecycle/arbitration scenarios and
// a 4-entry one for the cache-full case.
module tb_pcache_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pcache_arbiter_if #(.TAG_W(10)) m_if ();
    pcache_arbiter_if #(.TAG_W(2))  s_if ();

    pcache_arbiter #(.ENTRIES(1024), .TAG_W(10)) u_main (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (m_if)
    );

    pcache_arbiter #(.ENTRIES(4), .TAG_W(2)) u_small (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (s_if)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start_main;
        m_if.tile_start = 1'b1;
        tick();
        m_if.tile_start = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_vec++;
        if ({m_if.wr_gnt, m_if.rd0_gnt, m_if.rd1_gnt, m_if.rd0_valid, m_if.rd1_valid,
             m_if.rd0_err, m_if.rd1_err, m_if.flush_done, m_if.pcache_full,
             m_if.pcache_write, m_if.prim_tag, m_if.alloc_count} !== 29'd0) begin
            n_err++;
            $display("FAIL reset_outputs: prim_tag=%0d alloc=%0d gnts=%b%b%b", m_if.prim_tag,
                     m_if.alloc_count, m_if.wr_gnt, m_if.rd0_gnt, m_if.rd1_gnt);
        end
    endtask

    task automatic test_write_alloc;
        start_main();
        for (int i = 0; i < 3; i++) begin
            m_if.wr_req = 1'b1;
            tick();
            n_vec++;
            if ({m_if.wr_gnt, m_if.pcache_write, m_if.wr_tag} !== {2'b11, 10'(i)}) begin
                n_err++;
                $display("FAIL write_grant[%0d]: gnt=%b we=%b tag=%0d, expected 1 1 %0d",
                         i, m_if.wr_gnt, m_if.pcache_write, m_if.wr_tag, i);
            end
            m_if.wr_req = 1'b0;
            tick();
            n_vec++;
            if ({m_if.wr_gnt, m_if.pcache_write} !== 2'b00) begin
                n_err++;
                $display("FAIL write_release[%0d]: gnt=%b we=%b, expected 0 0",
                         i, m_if.wr_gnt, m_if.pcache_write);
            end
        end
        n_vec++;
        if (m_if.alloc_count !== 11'd3) begin
            n_err++;
            $display("FAIL alloc_after_3: got %0d expected 3", m_if.alloc_count);
        end
        // single read to leave rd1 as the last winner
        m_if.rd1_req = 1'b1;
        m_if.rd1_tag = 10'd0;
        tick();
        n_vec++;
        if ({m_if.rd1_gnt, m_if.prim_tag} !== {1'b1, 10'd0}) begin
            n_err++;
            $display("FAIL rd1_single_gnt: gnt=%b tag=%0d expected 1 0", m_if.rd1_gnt, m_if.prim_tag);
        end
        m_if.rd1_req = 1'b0;
        tick();
        n_vec++;
        if ({m_if.rd1_valid, m_if.rd1_err, m_if.rd1_gnt} !== 3'b100) begin
            n_err++;
            $display("FAIL rd1_single_valid: valid=%b err=%b gnt=%b expected 1 0 0",
                     m_if.rd1_valid, m_if.rd1_err, m_if.rd1_gnt);
        end
    endtask

    task automatic test_round_robin;
        m_if.wr_req  = 1'b1;
        m_if.rd0_req = 1'b1;
        m_if.rd0_tag = 10'd1;
        m_if.rd1_req = 1'b1;
        m_if.rd1_tag = 10'd2;
        tick();
        n_vec++;
        if ({m_if.wr_gnt, m_if.rd0_gnt, m_if.rd1_gnt, m_if.wr_tag} !== {3'b100, 10'd3}) begin
            n_err++;
            $display("FAIL rr_cycle1: gnts=%b%b%b tag=%0d expected 100 3",
                     m_if.wr_gnt, m_if.rd0_gnt, m_if.rd1_gnt, m_if.wr_tag);
        end
        m_if.wr_req = 1'b0;
        tick();
        n_vec++;
        if ({m_if.wr_gnt, m_if.rd0_gnt, m_if.rd1_gnt, m_if.prim_tag} !== {3'b010, 10'd1}) begin
            n_err++;
            $display("FAIL rr_cycle2: gnts=%b%b%b tag=%0d expected 010 1",
                     m_if.wr_gnt, m_if.rd0_gnt, m_if.rd1_gnt, m_if.prim_tag);
        end
        m_if.rd0_req = 1'b0;
        tick();
        n_vec++;
        if ({m_if.rd0_gnt, m_if.rd1_gnt, m_if.prim_tag, m_if.rd0_valid, m_if.rd0_err}
            !== {2'b01, 10'd2, 2'b10}) begin
            n_err++;
            $display("FAIL rr_cycle3: gnts=%b%b tag=%0d rd0_valid=%b rd0_err=%b expected 01 2 1 0",
                     m_if.rd0_gnt, m_if.rd1_gnt, m_if.prim_tag, m_if.rd0_valid, m_if.rd0_err);
        end
        m_if.rd1_req = 1'b0;
        tick();
        n_vec++;
        if ({m_if.rd1_valid, m_if.rd1_err, m_if.rd1_gnt, m_if.rd0_valid, m_if.prim_tag,
             m_if.alloc_count} !== {4'b1000, 10'd2, 11'd4}) begin
            n_err++;
            $display("FAIL rr_cycle4: rd1_valid=%b err=%b gnt=%b rd0_valid=%b tag=%0d alloc=%0d expected 1 0 0 0 2 4",
                     m_if.rd1_valid, m_if.rd1_err, m_if.rd1_gnt, m_if.rd0_valid, m_if.prim_tag,
                     m_if.alloc_count);
        end
    endtask

    task automatic test_full;
        s_if.tile_start = 1'b1;
        tick();
        s_if.tile_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_if.wr_req = 1'b1;
            tick();
            n_vec++;
            if ({s_if.wr_gnt, s_if.wr_tag, s_if.pcache_full} !== {1'b1, 2'(i), (i == 3)}) begin
                n_err++;
                $display("FAIL full_write[%0d]: gnt=%b tag=%0d full=%b expected 1 %0d %0d",
                         i, s_if.wr_gnt, s_if.wr_tag, s_if.pcache_full, i, (i == 3));
            end
            s_if.wr_req = 1'b0;
            tick();
        end
        s_if.wr_req  = 1'b1;
        s_if.rd0_req = 1'b1;
        s_if.rd0_tag = 2'd3;
        tick();
        n_vec++;
        if ({s_if.rd0_gnt, s_if.wr_gnt, s_if.prim_tag, s_if.pcache_full} !== {2'b10, 2'd3, 1'b1}) begin
            n_err++;
            $display("FAIL full_read_gnt: rd0_gnt=%b wr_gnt=%b tag=%0d full=%b expected 1 0 3 1",
                     s_if.rd0_gnt, s_if.wr_gnt, s_if.prim_tag, s_if.pcache_full);
        end
        s_if.rd0_req = 1'b0;
        tick();
        n_vec++;
        if ({s_if.rd0_valid, s_if.rd0_err, s_if.wr_gnt} !== 3'b100) begin
            n_err++;
            $display("FAIL full_read_valid: valid=%b err=%b wr_gnt=%b expected 1 0 0",
                     s_if.rd0_valid, s_if.rd0_err, s_if.wr_gnt);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({s_if.wr_gnt, s_if.alloc_count} !== {1'b0, 3'd4}) begin
                n_err++;
                $display("FAIL full_no_5th[%0d]: wr_gnt=%b alloc=%0d expected 0 4",
                         i, s_if.wr_gnt, s_if.alloc_count);
            end
        end
        s_if.wr_req = 1'b0;
    endtask

    task automatic test_read_err;
        do_reset();
        start_main();
        for (int i = 0; i < 2; i++) begin
            m_if.wr_req = 1'b1;
            tick();
            m_if.wr_req = 1'b0;
            tick();
        end
        m_if.rd1_req = 1'b1;
        m_if.rd1_tag = 10'd5;
        tick();
        n_vec++;
        if ({m_if.rd1_gnt, m_if.prim_tag, m_if.alloc_count} !== {1'b1, 10'd5, 11'd2}) begin
            n_err++;
            $display("FAIL err_gnt: gnt=%b tag=%0d alloc=%0d expected 1 5 2",
                     m_if.rd1_gnt, m_if.prim_tag, m_if.alloc_count);
        end
        m_if.rd1_req = 1'b0;
        tick();
        n_vec++;
        if ({m_if.rd1_valid, m_if.rd1_err} !== 2'b11) begin
            n_err++;
            $display("FAIL err_flag: valid=%b err=%b expected 1 1", m_if.rd1_valid, m_if.rd1_err);
        end
    endtask

    task automatic test_flush;
        m_if.rd0_req = 1'b1;
        m_if.rd0_tag = 10'd0;
        tick();
        n_vec++;
        if (m_if.rd0_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL flush_rd0_gnt: got %b expected 1", m_if.rd0_gnt);
        end
        m_if.rd0_req  = 1'b0;
        m_if.tile_end = 1'b1;
        m_if.wr_req   = 1'b1;
        tick();
        m_if.tile_end = 1'b0;
        n_vec++;
        if ({m_if.rd0_valid, m_if.wr_gnt, m_if.flush_done} !== 3'b100) begin
            n_err++;
            $display("FAIL flush_valid: rd0_valid=%b wr_gnt=%b flush_done=%b expected 1 0 0",
                     m_if.rd0_valid, m_if.wr_gnt, m_if.flush_done);
        end
        tick();
        n_vec++;
        if ({m_if.flush_done, m_if.wr_gnt} !== 2'b10) begin
            n_err++;
            $display("FAIL flush_done_pulse: flush_done=%b wr_gnt=%b expected 1 0",
                     m_if.flush_done, m_if.wr_gnt);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({m_if.flush_done, m_if.wr_gnt} !== 2'b00) begin
                n_err++;
                $display("FAIL flush_idle[%0d]: flush_done=%b wr_gnt=%b expected 0 0",
                         i, m_if.flush_done, m_if.wr_gnt);
            end
        end
        m_if.wr_req = 1'b0;
    endtask

    task automatic test_reset_midread;
        start_main();
        m_if.wr_req = 1'b1;
        tick();
        m_if.wr_req  = 1'b0;
        m_if.rd1_req = 1'b1;
        m_if.rd1_tag = 10'd7;
        tick();
        n_vec++;
        if ({m_if.rd1_gnt, m_if.prim_tag, m_if.alloc_count} !== {1'b1, 10'd7, 11'd1}) begin
            n_err++;
            $display("FAIL midreset_gnt: gnt=%b tag=%0d alloc=%0d expected 1 7 1",
                     m_if.rd1_gnt, m_if.prim_tag, m_if.alloc_count);
        end
        m_if.rd1_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({m_if.rd1_valid, m_if.rd1_err, m_if.rd1_gnt, m_if.wr_gnt, m_if.rd0_gnt,
             m_if.flush_done, m_if.pcache_write, m_if.prim_tag, m_if.alloc_count} !== 28'd0) begin
            n_err++;
            $display("FAIL midreset_clear: rd1_valid=%b rd1_gnt=%b tag=%0d alloc=%0d expected all 0",
                     m_if.rd1_valid, m_if.rd1_gnt, m_if.prim_tag, m_if.alloc_count);
        end
        tick();
        n_vec++;
        if ({m_if.rd1_valid, m_if.rd1_gnt, m_if.alloc_count} !== 13'd0) begin
            n_err++;
            $display("FAIL midreset_after: rd1_valid=%b rd1_gnt=%b alloc=%0d expected 0 0 0",
                     m_if.rd1_valid, m_if.rd1_gnt, m_if.alloc_count);
        end
    endtask

    initial begin
        m_if.tile_start = 1'b0; m_if.tile_end = 1'b0; m_if.wr_req = 1'b0;
        m_if.rd0_req = 1'b0; m_if.rd0_tag = '0; m_if.rd1_req = 1'b0; m_if.rd1_tag = '0;
        s_if.tile_start = 1'b0; s_if.tile_end = 1'b0; s_if.wr_req = 1'b0;
        s_if.rd0_req = 1'b0; s_if.rd0_tag = '0; s_if.rd1_req = 1'b0; s_if.rd1_tag = '0;
        test_reset();
        test_write_alloc();
        test_round_robin();
        test_full();
        test_read_err();
        test_flush();
        test_reset_midread();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end
endmodule
